// File: rtl/conv_stream_arbiter_if.sv
// Bundle of the three streaming interfaces around the shared conv engine:
// requester side (R packed streams), engine x/y side and tagged result side,
// plus the arbiter status outputs.
interface conv_stream_arbiter_if #(
    parameter int R = 4,
    parameter int T = 16
);
    localparam int IDW = (R > 1) ? $clog2(R) : 1;

    logic        [R*T-1:0] req_data;
    logic        [R-1:0]   req_valid;
    logic        [R-1:0]   req_ready;

    logic signed [T-1:0]   eng_x_data;
    logic                  eng_x_valid;
    logic                  eng_x_ready;

    logic signed [T-1:0]   eng_y_data;
    logic                  eng_y_valid;
    logic                  eng_y_ready;

    logic signed [T-1:0]   y_data;
    logic                  y_valid;
    logic                  y_ready;
    logic        [IDW-1:0] y_id;
    logic                  y_last;

    logic        [R-1:0]   grant;
    logic                  busy;
    logic                  err;

    // Arbiter side
    modport slave (
        input  req_data, req_valid, eng_x_ready, eng_y_data, eng_y_valid, y_ready,
        output req_ready, eng_x_data, eng_x_valid, eng_y_ready,
        output y_data, y_valid, y_id, y_last, grant, busy, err
    );

    // Environment side: stream sources, conv engine and result sink
    modport master (
        output req_data, req_valid, eng_x_ready, eng_y_data, eng_y_valid, y_ready,
        input  req_ready, eng_x_data, eng_x_valid, eng_y_ready,
        input  y_data, y_valid, y_id, y_last, grant, busy, err
    );
endinterface

// File: rtl/conv_stream_arbiter.sv
// Frame-granular round-robin arbiter sharing one conv engine among R streams.
// The owner streams N samples straight into the engine, then the L results
// are passed back tagged with the owner's index and a last flag.
module conv_stream_arbiter #(
    parameter int R = 4,
    parameter int N = 96,
    parameter int M = 65,
    parameter int T = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    conv_stream_arbiter_if.slave  bus
);
    localparam int L    = N - M + 1;
    localparam int IDW  = (R > 1) ? $clog2(R) : 1;
    localparam int INW  = $clog2(N) + 1;
    localparam int OUTW = $clog2(L) + 1;

    localparam logic [IDW:0]    R_W      = (IDW + 1)'(R);
    localparam logic [IDW-1:0]  OWN_LAST = IDW'(R - 1);
    localparam logic [INW-1:0]  IN_LAST  = INW'(N - 1);
    localparam logic [OUTW-1:0] OUT_LAST = OUTW'(L - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [INW-1:0]  in_cnt_q, in_cnt_d;
    logic [OUTW-1:0] out_cnt_q, out_cnt_d;
    logic            err_q, err_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic [IDW:0]    cand;
    logic            x_hs;
    logic            y_hs;

    // Circular search for the first valid requester starting at rr_ptr
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < R; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
            if (cand >= R_W) begin
                cand = cand - R_W;
            end
            if (!pick_found && bus.req_valid[cand[IDW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDW-1:0];
            end
        end
    end

    // Next-state logic and the state-gated pass-through muxes
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q | (bus.eng_y_valid && (state_q != DRAIN));

        bus.req_ready   = '0;
        bus.eng_x_data  = '0;
        bus.eng_x_valid = 1'b0;
        bus.eng_y_ready = 1'b0;
        bus.y_data      = '0;
        bus.y_valid     = 1'b0;
        bus.y_id        = '0;
        bus.y_last      = 1'b0;
        bus.grant       = '0;
        x_hs            = 1'b0;
        y_hs            = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d  = pick_idx;
                    in_cnt_d = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                bus.eng_x_data         = bus.req_data[int'(owner_q)*T +: T];
                bus.eng_x_valid        = bus.req_valid[owner_q];
                bus.req_ready[owner_q] = bus.eng_x_ready;
                bus.grant[owner_q]     = 1'b1;
                x_hs = bus.req_valid[owner_q] && bus.eng_x_ready;
                if (x_hs) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == IN_LAST) begin
                        state_d   = DRAIN;
                        out_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                bus.y_data         = bus.eng_y_data;
                bus.y_valid        = bus.eng_y_valid;
                bus.eng_y_ready    = bus.y_ready;
                bus.y_id           = owner_q;
                bus.y_last         = (out_cnt_q == OUT_LAST);
                bus.grant[owner_q] = 1'b1;
                y_hs = bus.eng_y_valid && bus.y_ready;
                if (y_hs) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == OUT_LAST) begin
                        state_d  = IDLE;
                        rr_ptr_d = (owner_q == OWN_LAST) ? '0 : owner_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.err  = err_q;

    // State, ownership, counters and sticky error register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_conv_stream_arbiter.sv
// Bench for conv_stream_arbiter: acts as R stream sources, the conv engine
// and the result sink; expected x samples and tagged y results are queued
// per granted frame and checked by an independent monitor.
module tb_conv_stream_arbiter;
    localparam int R   = 4;
    localparam int N   = 96;
    localparam int M   = 65;
    localparam int T   = 16;
    localparam int L   = N - M + 1;
    localparam int IDW = $clog2(R);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_stream_arbiter_if #(.R(R), .T(T)) bus ();

    conv_stream_arbiter #(.R(R), .N(N), .M(M), .T(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic signed [T-1:0] data;
        logic [IDW-1:0]      id;
        logic                last;
    } yexp_t;

    logic signed [T-1:0] xq[$];
    yexp_t               yq[$];

    int vectors = 0;
    int miscompares = 0;

    int src_cnt[R];
    int src_lim[R];
    int px[R];
    int gap_req, gap_at, gap_left, gap_hits;
    int eng_x_cnt, eng_y_cnt, eng_frame, exp_frame, cyc;
    bit eng_emit, inject_y, yr_toggle;
    logic [R-1:0] hs_req;
    bit hs_ex, hs_ey;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic signed [T-1:0] src_val(input int i, input int k);
        return T'(i * 128 + (k % N) + 1);
    endfunction

    function automatic logic signed [T-1:0] eng_val(input int f, input int j);
        return T'(-(f * 40 + j + 1));
    endfunction

    task automatic push_frame(input int o);
        yexp_t e;
        for (int k = 0; k < N; k++) xq.push_back(src_val(o, px[o] + k));
        px[o] += N;
        for (int j = 0; j < L; j++) begin
            e.data = eng_val(exp_frame, j);
            e.id   = IDW'(o);
            e.last = (j == L - 1);
            yq.push_back(e);
        end
        exp_frame++;
    endtask

    task automatic clear_env();
        for (int i = 0; i < R; i++) begin
            src_cnt[i] = 0; src_lim[i] = 0; px[i] = 0;
        end
        gap_req = -1; gap_at = 0; gap_left = 0; gap_hits = 0;
        eng_x_cnt = 0; eng_y_cnt = 0; eng_frame = 0; exp_frame = 0;
        eng_emit = 0; inject_y = 0; yr_toggle = 0;
        hs_req = '0; hs_ex = 0; hs_ey = 0;
        xq.delete(); yq.delete();
        bus.req_data = '0; bus.req_valid = '0; bus.eng_x_ready = 1'b0;
        bus.eng_y_data = '0; bus.eng_y_valid = 1'b0; bus.y_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_env();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock of environment: commit last cycle's handshakes, drive, check
    task automatic step();
        logic [R*T-1:0] d;
        logic [R-1:0]   v;
        bit             gap_hit;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < R; i++) if (hs_req[i]) src_cnt[i]++;
        if (hs_ex) begin
            eng_x_cnt++;
            if (eng_x_cnt == N) begin
                eng_x_cnt = 0; eng_emit = 1; eng_y_cnt = 0;
            end
        end
        if (hs_ey && eng_emit) begin
            eng_y_cnt++;
            if (eng_y_cnt == L) begin
                eng_emit = 0; eng_frame++;
            end
        end
        d = '0; v = '0; gap_hit = 0;
        for (int i = 0; i < R; i++) begin
            d[i*T +: T] = src_val(i, src_cnt[i]);
            v[i] = (src_cnt[i] < src_lim[i]);
            if (i == gap_req && src_cnt[i] == gap_at && gap_left > 0 && v[i]) begin
                v[i] = 1'b0; gap_left--; gap_hit = 1; gap_hits++;
            end
        end
        bus.req_data    = d;
        bus.req_valid   = v;
        bus.eng_x_ready = 1'b1;
        bus.eng_y_valid = eng_emit | inject_y;
        bus.eng_y_data  = eng_emit ? eng_val(eng_frame, eng_y_cnt) : (inject_y ? 16'sh1234 : '0);
        inject_y = 0;
        bus.y_ready = yr_toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        #1;
        hs_req = bus.req_valid & bus.req_ready;
        hs_ex  = bus.eng_x_valid && bus.eng_x_ready;
        hs_ey  = bus.eng_y_valid && bus.eng_y_ready;
        chk("grant_onehot0", 32'($onehot0(bus.grant)), 1);
        chk("nonowner_ready", 32'(bus.req_ready & ~bus.grant), 0);
        if (gap_hit) chk("gap_eng_x_valid", 32'(bus.eng_x_valid), 0);
        if (eng_emit) begin
            chk("drain_eng_y_ready", 32'(bus.eng_y_ready), 32'(bus.y_ready));
        end else begin
            chk("idle_load_y_valid", 32'(bus.y_valid), 0);
            chk("idle_load_eng_y_ready", 32'(bus.eng_y_ready), 0);
        end
    endtask

    task automatic run_done(input string nm, input int maxc);
        int c;
        c = 0;
        while ((xq.size() != 0 || yq.size() != 0 || eng_emit) && c < maxc) begin
            step();
            c++;
        end
        chk({nm, "_complete"}, 32'(c < maxc), 1);
    endtask

    task automatic run_until_cnt(input string nm, input int i, input int target, input int maxc);
        int c;
        c = 0;
        while (src_cnt[i] < target && c < maxc) begin
            step();
            c++;
        end
        chk({nm, "_reach"}, 32'(src_cnt[i]), 32'(target));
    endtask

    // Scoreboard monitor: pops one expectation per output handshake
    logic signed [T-1:0] mon_x;
    yexp_t               mon_y;
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (bus.eng_x_valid && bus.eng_x_ready) begin
                if (xq.size() == 0) begin
                    chk("x_unexpected", 32'(bus.eng_x_data), 0);
                    chk("x_extra_handshake", 1, 0);
                end else begin
                    mon_x = xq.pop_front();
                    chk("x_data", 32'(bus.eng_x_data), 32'(mon_x));
                end
            end
            if (bus.y_valid && bus.y_ready) begin
                if (yq.size() == 0) begin
                    chk("y_extra_handshake", 32'(bus.y_data), 32'hdead);
                end else begin
                    mon_y = yq.pop_front();
                    chk("y_data", 32'(bus.y_data), 32'(mon_y.data));
                    chk("y_id", 32'(bus.y_id), 32'(mon_y.id));
                    chk("y_last", 32'(bus.y_last), 32'(mon_y.last));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        cyc = 0;
        reset = 1'b1;
        clear_env();
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_eng_x_valid", 32'(bus.eng_x_valid), 0);
        chk("rst_y_valid", 32'(bus.y_valid), 0);
        chk("rst_y_last", 32'(bus.y_last), 0);
        do_reset();

        // Single requester 2, steady flow
        src_lim[2] = N;
        push_frame(2);
        run_done("t1", 400);
        chk("t1_busy_after", 32'(bus.busy), 0);
        chk("t1_grant_after", 32'(bus.grant), 0);

        // rr_ptr is 3 now: 0 and 3 both ask, 3 wins, then wrap to 0
        src_lim[0] = N; src_lim[3] = N;
        push_frame(3);
        push_frame(0);
        run_done("t1_rr", 800);

        // All four from reset, with downstream ready toggling 1,0,0,1
        do_reset();
        src_lim[0] = 2 * N; src_lim[1] = N; src_lim[2] = N; src_lim[3] = N;
        yr_toggle = 1;
        push_frame(0); push_frame(1); push_frame(2); push_frame(3); push_frame(0);
        run_done("t2_t3", 2500);
        yr_toggle = 0;

        // Owner 1 stalls 5 cycles at sample 40
        gap_req = 1; gap_at = src_cnt[1] + 40; gap_left = 5; gap_hits = 0;
        src_lim[1] += N;
        push_frame(1);
        run_done("t4", 400);
        chk("t4_gap_cycles", 32'(gap_hits), 5);
        gap_req = -1;

        // rr_ptr is 2: owner 2 aborted by async reset at sample 50
        base = src_cnt[2];
        for (int i = 0; i < R; i++) src_lim[i] += N;
        push_frame(2);
        run_until_cnt("t5", 2, base + 50, 200);
        chk("t5_busy_midframe", 32'(bus.busy), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_busy", 32'(bus.busy), 0);
        chk("t5_async_grant", 32'(bus.grant), 0);
        chk("t5_async_req_ready", 32'(bus.req_ready), 0);
        chk("t5_async_eng_x_valid", 32'(bus.eng_x_valid), 0);
        chk("t5_async_eng_x_data", 32'(bus.eng_x_data), 0);
        clear_env();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        src_lim[0] = N; src_lim[3] = N;
        push_frame(0);
        push_frame(3);
        run_done("t5_after", 800);

        // Stray engine output during LOAD sets a sticky error
        chk("t6_err_before", 32'(bus.err), 0);
        base = src_cnt[1];
        src_lim[1] += N;
        push_frame(1);
        run_until_cnt("t6", 1, base + 10, 100);
        inject_y = 1;
        step();
        step();
        chk("t6_err_set", 32'(bus.err), 1);
        run_done("t6_frame", 400);
        src_lim[2] += N;
        push_frame(2);
        run_done("t6_next", 400);
        chk("t6_err_held", 32'(bus.err), 1);
        do_reset();
        chk("t6_err_cleared", 32'(bus.err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
